// File: rtl/ram_loader_pkg.sv
// Shared types and default sizes for the RAM16K loader.
package ram_loader_pkg;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_ADDR_W = 14;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FILL   = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/ram_loader.sv
// Loads a RAM16K either from a valid/ready word stream or with a constant fill.
// Optional running checksum of written words: define LOADER_CHECKSUM_EN.
module ram_loader
  import ram_loader_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W:0]   count,
  input  logic [WIDTH-1:0]  fill_value,
  input  logic              abort,
  input  logic [WIDTH-1:0]  s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [WIDTH-1:0]  ram_in,
  output logic              ram_load,
  output logic [ADDR_W-1:0] ram_address,
  output logic              busy,
  output logic              done
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [WIDTH-1:0]  checksum
`endif
);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0]   remaining;
  logic [WIDTH-1:0]  fill_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      remaining <= '0;
      fill_q    <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        ptr       <= base;
        remaining <= count;
        fill_q    <= fill_value;
      end else if (ram_load) begin
        ptr       <= ptr + 1'b1;
        remaining <= remaining - 1'b1;
      end
    end
  end

  // Reset and abort both kill the current cycle's write so a job never
  // produces a partial extra word on its way out.
  always_comb begin
    state_nxt   = state;
    s_ready     = 1'b0;
    ram_load    = 1'b0;
    ram_in      = '0;
    ram_address = ptr;
    busy        = 1'b0;
    done        = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (count == '0) state_nxt = DONE;
          else             state_nxt = mode ? FILL : STREAM;
        end
      end
      STREAM: begin
        busy = 1'b1;
        if (abort || reset) begin
          state_nxt = IDLE;
        end else begin
          s_ready = 1'b1;
          if (s_valid) begin
            ram_load = 1'b1;
            ram_in   = s_data;
            if (remaining == 1) state_nxt = DONE;
          end
        end
      end
      FILL: begin
        busy = 1'b1;
        if (abort || reset) begin
          state_nxt = IDLE;
        end else begin
          ram_load = 1'b1;
          ram_in   = fill_q;
          if (remaining == 1) state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (reset)                     checksum <= '0;
    else if (state == IDLE && start) checksum <= '0;
    else if (ram_load)             checksum <= checksum + ram_in;
  end
`endif

endmodule

// File: tb/tb_ram_loader.sv
// Directed self-checking bench for ram_loader (fill, stream, wrap, gaps, abort, reset).
`timescale 1ns/1ps
module tb_ram_loader;

  localparam int WIDTH  = 16;
  localparam int ADDR_W = 14;

  logic              clk = 1'b0;
  logic              reset, start, mode, abort, s_valid;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W:0]   count;
  logic [WIDTH-1:0]  fill_value, s_data;
  logic              s_ready, ram_load, busy, done;
  logic [WIDTH-1:0]  ram_in;
  logic [ADDR_W-1:0] ram_address;
`ifdef LOADER_CHECKSUM_EN
  logic [WIDTH-1:0]  checksum;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  ram_loader #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .base(base),
    .count(count), .fill_value(fill_value), .abort(abort),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .ram_in(ram_in), .ram_load(ram_load), .ram_address(ram_address),
    .busy(busy), .done(done)
`ifdef LOADER_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic m, input logic [ADDR_W-1:0] b,
                           input logic [ADDR_W:0] c, input logic [WIDTH-1:0] f);
    mode = m; base = b; count = c; fill_value = f; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; abort = 1'b1; s_valid = 1'b0; s_data = '0;
    mode = 1'b1; base = 14'h0123; count = 15'd5; fill_value = 16'hAAAA;
    tick(); tick();
    reset = 1'b0; start = 1'b0; abort = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({busy, done, ram_load, s_ready} !== 4'b0000 || ram_address !== 14'h0 || ram_in !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b done=%b load=%b rdy=%b addr=%h in=%h, want all 0",
               busy, done, ram_load, s_ready, ram_address, ram_in);
    end
    tick();
  endtask

  task automatic test_fill();
    start_job(1'b1, 14'h0010, 15'd4, 16'hBEEF);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_tests++;
      if (ram_load !== 1'b1 || ram_address !== 14'(16 + i) || ram_in !== 16'hBEEF || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL fill_write%0d: load=%b addr=%h in=%h busy=%b, want 1 %h beef 1",
                 i, ram_load, ram_address, ram_in, busy, 14'(16 + i));
      end
      tick();
    end
    @(negedge clk);
    n_tests++;
    if (done !== 1'b1 || ram_load !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_done: done=%b load=%b busy=%b, want 1 0 0", done, ram_load, busy);
    end
    tick();
    @(negedge clk);
    n_tests++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_done_once: done=%b, want 0", done);
    end
  endtask

  task automatic test_stream_wrap();
    logic [ADDR_W-1:0] exp_addr [3] = '{14'h3FFE, 14'h3FFF, 14'h0000};
    start_job(1'b0, 14'h3FFE, 15'd3, 16'h0);
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1; s_data = 16'(i + 1);
      @(negedge clk);
      n_tests++;
      if (s_ready !== 1'b1 || ram_load !== 1'b1 || ram_address !== exp_addr[i] || ram_in !== 16'(i + 1)) begin
        n_fail++;
        $display("FAIL wrap_write%0d: rdy=%b load=%b addr=%h in=%h, want 1 1 %h %h",
                 i, s_ready, ram_load, ram_address, ram_in, exp_addr[i], 16'(i + 1));
      end
      tick();
    end
    s_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (done !== 1'b1 || s_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_done: done=%b rdy=%b, want 1 0", done, s_ready);
    end
`ifdef LOADER_CHECKSUM_EN
    n_tests++;
    if (checksum !== 16'd6) begin
      n_fail++;
      $display("FAIL wrap_checksum: got %0d, want 6", checksum);
    end
`endif
    tick();
  endtask

  task automatic test_stream_gap();
    logic             vld [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [WIDTH-1:0] dat [6] = '{16'h000A, 16'h000B, 16'hFFFF, 16'hFFFF, 16'h000C, 16'h000D};
    logic [ADDR_W-1:0] exp_a [6] = '{14'h100, 14'h101, 14'h102, 14'h102, 14'h102, 14'h103};
    start_job(1'b0, 14'h0100, 15'd4, 16'h0);
    for (int i = 0; i < 6; i++) begin
      s_valid = vld[i]; s_data = dat[i];
      @(negedge clk);
      n_tests++;
      if (ram_load !== vld[i] || ram_address !== exp_a[i] || s_ready !== 1'b1 ||
          ram_in !== (vld[i] ? dat[i] : 16'h0)) begin
        n_fail++;
        $display("FAIL gap_cycle%0d: load=%b addr=%h in=%h rdy=%b, want %b %h %h 1",
                 i, ram_load, ram_address, ram_in, s_ready, vld[i], exp_a[i],
                 vld[i] ? dat[i] : 16'h0);
      end
      tick();
    end
    s_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL gap_done: done=%b, want 1", done);
    end
    tick();
  endtask

  task automatic test_count_zero();
    start_job(1'b1, 14'h0055, 15'd0, 16'h1111);
    @(negedge clk);
    n_tests++;
    if (done !== 1'b1 || ram_load !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_count: done=%b load=%b busy=%b, want 1 0 0", done, ram_load, busy);
    end
    // start raised while in DONE must be ignored
    start = 1'b1; mode = 1'b1; count = 15'd5;
    tick();
    start = 1'b0;
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0 || ram_load !== 1'b0) begin
      n_fail++;
      $display("FAIL start_in_done: busy=%b done=%b load=%b, want 0 0 0", busy, done, ram_load);
    end
    tick();
  endtask

  task automatic run_kill(input bit use_reset, input string name);
    int writes = 0;
    int dones  = 0;
    start_job(1'b1, 14'h0200, 15'd100, 16'h1234);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (ram_load === 1'b1) writes++;
      tick();
    end
    if (use_reset) reset = 1'b1; else abort = 1'b1;
    @(negedge clk);
    n_tests++;
    if (ram_load !== 1'b0 || s_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_suppress: load=%b rdy=%b, want 0 0", name, ram_load, s_ready);
    end
    tick();
    reset = 1'b0; abort = 1'b0;
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0 ||
        ram_address !== (use_reset ? 14'h0000 : 14'h0209)) begin
      n_fail++;
      $display("FAIL %s_after: busy=%b done=%b addr=%h, want 0 0 %h", name, busy, done,
               ram_address, use_reset ? 14'h0000 : 14'h0209);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
      if (ram_load === 1'b1) writes++;
      tick();
    end
    n_tests++;
    if (writes !== 9 || dones !== 0) begin
      n_fail++;
      $display("FAIL %s_count: writes=%0d dones=%0d, want 9 0", name, writes, dones);
    end
  endtask

  task automatic test_abort();
    run_kill(1'b0, "abort");
  endtask

  task automatic test_reset_midjob();
    run_kill(1'b1, "reset_mid");
  endtask

  task automatic test_full_range();
    bit                seen [1 << ADDR_W];
    int                errs = 0;
    logic [ADDR_W-1:0] last = '0;
    for (int i = 0; i < (1 << ADDR_W); i++) seen[i] = 1'b0;
    start_job(1'b1, 14'h1234, 15'h4000, 16'h5A5A);
    for (int i = 0; i < (1 << ADDR_W); i++) begin
      @(negedge clk);
      if (ram_load !== 1'b1 || seen[ram_address]) errs++;
      else seen[ram_address] = 1'b1;
      last = ram_address;
      tick();
    end
    for (int i = 0; i < (1 << ADDR_W); i++) if (!seen[i]) errs++;
    n_tests++;
    if (errs !== 0 || last !== 14'h1233) begin
      n_fail++;
      $display("FAIL full_range: errors=%0d last=%h, want 0 1233", errs, last);
    end
    @(negedge clk);
    n_tests++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL full_range_done: done=%b, want 1", done);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_stream_wrap();
    test_stream_gap();
    test_count_zero();
    test_abort();
    test_reset_midjob();
    test_full_range();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
